// File: rtl/fir_pkg.sv
// Shared definitions for the time-multiplexed FIR engine: state encoding,
// default widths and a constant clog2 helper used for index widths.
package fir_pkg;

    localparam int DW_DEF   = 13;
    localparam int TAPS_DEF = 8;
    localparam int ACCW_DEF = 29;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

    // Ceiling log2, at least 1 so a 2-tap filter still gets a 1-bit index.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fir_delay_line.sv
// Sample history x[] for the FIR: x[0] is the newest sample. Shifts once per
// accepted sample and exposes one entry combinationally at the tap index.
module fir_delay_line
    import fir_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int TAPS = TAPS_DEF,
    localparam int AW  = clog2(TAPS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          shift_en,
    input  logic [DW-1:0] din,
    input  logic [AW-1:0] rd_idx,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] x [TAPS];

    // Clear the history on reset; push the new sample in at x[0] on accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < TAPS; k++) begin
                x[k] <= '0;
            end
        end else if (shift_en) begin
            x[0] <= din;
            for (int k = 1; k < TAPS; k++) begin
                x[k] <= x[k-1];
            end
        end
    end

    assign rd_data = x[rd_idx];

endmodule

// File: rtl/mul.sv
// Combinational unsigned shift-add multiplier; the single arithmetic
// resource shared by every tap of the filter.
module mul #(
    parameter int AW = 13,
    parameter int BW = 13
) (
    input  logic [AW-1:0]    a,
    input  logic [BW-1:0]    b,
    output logic [AW+BW-1:0] p
);

    // Sum a shifted copy of a for every set bit of b.
    always_comb begin
        p = '0;
        for (int i = 0; i < BW; i++) begin
            if (b[i]) begin
                p = p + ((AW + BW)'(a) << i);
            end
        end
    end

endmodule

// File: rtl/fir_mac_scheduler.sv
// Time-multiplexed FIR engine: one shared multiplier walks the taps of a
// TAPS-tap dot product, one result per accepted sample. Owns the coefficient
// table and sequences the delay line, multiplier and accumulator.
module fir_mac_scheduler
    import fir_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int TAPS = TAPS_DEF,
    parameter int ACCW = ACCW_DEF,
    localparam int AW  = clog2(TAPS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   din,
    input  logic            coef_we,
    input  logic [AW-1:0]   coef_addr,
    input  logic [DW-1:0]   coef_wdata,
    output logic            coef_rej,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ACCW-1:0] dout,
    output logic            busy
);

    state_t              state;
    logic [AW-1:0]       tap;
    logic [DW-1:0]       coef [TAPS];
    logic [DW-1:0]       x_tap;
    logic [2*DW-1:0]     prod;
    logic [2*DW-1:0]     prod_q;
    logic                prod_vld;
    logic [ACCW-1:0]     acc;
    logic [ACCW-1:0]     acc_sum;
    logic                accept;

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign accept   = in_valid && in_ready;
    assign acc_sum  = acc + ACCW'(prod_q);

    fir_delay_line #(
        .DW   (DW),
        .TAPS (TAPS)
    ) u_delay (
        .clk      (clk),
        .rst      (rst),
        .shift_en (accept),
        .din      (din),
        .rd_idx   (tap),
        .rd_data  (x_tap)
    );

    mul #(
        .AW (DW),
        .BW (DW)
    ) u_mul (
        .a (x_tap),
        .b (coef[tap]),
        .p (prod)
    );

    // Sequencer: accept a sample, stream TAPS products through a one-deep
    // product register into the accumulator, then hold the result for the sink.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tap       <= '0;
            prod_q    <= '0;
            prod_vld  <= 1'b0;
            acc       <= '0;
            out_valid <= 1'b0;
            dout      <= '0;
        end else begin
            prod_vld <= (state == MAC);
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc   <= '0;
                        tap   <= '0;
                        state <= MAC;
                    end
                end
                MAC: begin
                    prod_q <= prod;
                    if (prod_vld) begin
                        acc <= acc_sum;
                    end
                    tap <= tap + AW'(1);
                    if (tap == AW'(TAPS - 1)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    acc       <= acc_sum;
                    dout      <= acc_sum;
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Coefficient table: writes land only while idle so an in-flight result
    // never sees a mix of old and new coefficients; others are flagged.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < TAPS; k++) begin
                coef[k] <= '0;
            end
            coef_rej <= 1'b0;
        end else begin
            coef_rej <= 1'b0;
            if (coef_we) begin
                if (state == IDLE) begin
                    coef[coef_addr] <= coef_wdata;
                end else begin
                    coef_rej <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Directed bench for fir_mac_scheduler with hand-computed expected results.
module tb_fir_mac_scheduler;

    localparam int DW   = 13;
    localparam int TAPS = 8;
    localparam int ACCW = 29;
    localparam int AW   = 3;
    localparam int SQ   = 67092481;   // 8191*8191

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   din;
    logic            coef_we;
    logic [AW-1:0]   coef_addr;
    logic [DW-1:0]   coef_wdata;
    logic            coef_rej;
    logic            out_valid;
    logic            out_ready;
    logic [ACCW-1:0] dout;
    logic            busy;

    int tests = 0;
    int fails = 0;

    fir_mac_scheduler #(
        .DW   (DW),
        .TAPS (TAPS),
        .ACCW (ACCW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .din        (din),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .coef_rej   (coef_rej),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .dout       (dout),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Present a sample, wait (bounded) for in_ready, and consume the accept edge.
    task automatic applyStimulus(input logic [DW-1:0] d);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        din      = d;
        while (in_ready !== 1'b1 && guard < 60) begin
            tick();
            guard++;
        end
        if (guard >= 60) checkOutput("accept_timeout", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        din      = '0;
    endtask

    task automatic waitResult(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        if (n >= 60) checkOutput("result_timeout", {31'd0, out_valid}, 32'd1);
    endtask

    task automatic writeCoef(input logic [AW-1:0] a, input logic [DW-1:0] d);
        coef_we    = 1'b1;
        coef_addr  = a;
        coef_wdata = d;
        tick();
        coef_we    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        int seen;
        rst        = 1'b1;
        in_valid   = 1'b0;
        din        = '0;
        coef_we    = 1'b0;
        coef_addr  = '0;
        coef_wdata = '0;
        out_ready  = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // 1. reset state
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_dout", {3'd0, dout}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_coef_rej", {31'd0, coef_rej}, 32'd0);
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // 2. impulse response with c = 1..8
        for (int k = 0; k < TAPS; k++) writeCoef(AW'(k), DW'(k + 1));
        for (int i = 0; i <= TAPS; i++) begin
            applyStimulus((i == 0) ? DW'(1) : DW'(0));
            waitResult(n);
            checkOutput($sformatf("impulse_lat%0d", i), n + 1, 32'd10);
            checkOutput($sformatf("impulse_y%0d", i), {3'd0, dout}, (i < TAPS) ? i + 1 : 0);
            tick();
        end

        // 3. full scale
        for (int k = 0; k < TAPS; k++) writeCoef(AW'(k), DW'(8191));
        for (int i = 0; i < TAPS; i++) begin
            applyStimulus(DW'(8191));
            waitResult(n);
            checkOutput($sformatf("full_y%0d", i), {3'd0, dout}, (i + 1) * SQ);
            tick();
        end

        // 4. backpressure
        out_ready = 1'b0;
        applyStimulus(DW'(8191));
        waitResult(n);
        in_valid = 1'b1;
        din      = '0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput($sformatf("bp_dout%0d", i), {3'd0, dout}, 32'd536739848);
            checkOutput($sformatf("bp_in_ready%0d", i), {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        tick();
        checkOutput("bp_ready_after_hs", {31'd0, in_ready}, 32'd1);
        checkOutput("bp_idle_after_hs", {31'd0, busy}, 32'd0);
        tick();
        in_valid = 1'b0;
        checkOutput("bp_accepted", {31'd0, busy}, 32'd1);
        waitResult(n);
        checkOutput("bp_next_y", {3'd0, dout}, 7 * SQ);
        tick();

        // 5. coefficient write during MAC is rejected
        applyStimulus(DW'(2));
        coef_we    = 1'b1;
        coef_addr  = '0;
        coef_wdata = DW'(5);
        tick();
        coef_we = 1'b0;
        checkOutput("rej_pulse", {31'd0, coef_rej}, 32'd1);
        tick();
        checkOutput("rej_single", {31'd0, coef_rej}, 32'd0);
        waitResult(n);
        checkOutput("rej_old_coef_y", {3'd0, dout}, 2 * 8191 + 6 * SQ);
        tick();
        applyStimulus(DW'(3));
        waitResult(n);
        checkOutput("rej_c0_kept", {3'd0, dout}, 5 * 8191 + 5 * SQ);
        tick();

        // 6. reset mid-MAC
        applyStimulus(DW'(1));
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
        checkOutput("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("midrst_dout", {3'd0, dout}, 32'd0);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (out_valid === 1'b1) seen = 1;
        end
        checkOutput("midrst_no_output", seen, 32'd0);
        applyStimulus(DW'(1));
        waitResult(n);
        checkOutput("midrst_cleared_coef_y", {3'd0, dout}, 32'd0);
        tick();
        writeCoef(AW'(0), DW'(5));
        applyStimulus(DW'(7));
        waitResult(n);
        checkOutput("reload_y", {3'd0, dout}, 32'd35);
        tick();

        // coefficient write in the same idle cycle as an accept
        coef_we    = 1'b1;
        coef_addr  = AW'(1);
        coef_wdata = DW'(3);
        applyStimulus(DW'(0));
        coef_we = 1'b0;
        checkOutput("same_cycle_no_rej", {31'd0, coef_rej}, 32'd0);
        waitResult(n);
        checkOutput("same_cycle_write_y", {3'd0, dout}, 32'd21);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
